// File: rtl/alerm_set_pkg.sv
// Shared alarm-time definitions: FSM states, field codes, BCD limits and
// the digit layout of the 24-bit time word used by setter, timer and comparator.
package alerm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  // Time word is {Ht,Ho,Mt,Mo,St,So}, one BCD nibble per digit.
  localparam int TIME_W   = 24;
  localparam int FIELD_W  = 8;
  localparam int HOUR_LSB = 16;
  localparam int MIN_LSB  = 8;
  localparam int SEC_LSB  = 0;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic state_t next_state(input state_t s);
    state_t n;
    case (s)
      IDLE:     n = SET_HOUR;
      SET_HOUR: n = SET_MIN;
      SET_MIN:  n = SET_SEC;
      default:  n = IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] field_of(input state_t s);
    logic [1:0] f;
    case (s)
      SET_HOUR: f = FIELD_HOUR;
      SET_MIN:  f = FIELD_MIN;
      SET_SEC:  f = FIELD_SEC;
      default:  f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alerm_set_if.sv
// Front-panel key inputs and alarm-setting outputs; master is the key/panel
// side, slave is the alarm setter.
interface alerm_set_if;
  import alerm_pkg::*;

  logic              set_key;
  logic              inc_key;
  logic              enable_key;
  logic [TIME_W-1:0] alerm_data;
  logic              alerm_enable;
  logic [1:0]        edit_field;

  modport master (
    output set_key, inc_key, enable_key,
    input  alerm_data, alerm_enable, edit_field
  );

  modport slave (
    input  set_key, inc_key, enable_key,
    output alerm_data, alerm_enable, edit_field
  );

endinterface

// File: rtl/alerm_set_key_ctrl.sv
// Per-key press detector with optional hold-to-repeat; the action pulse is
// combinational off the registered history so the consumer acts on the press edge.
module alerm_key_ctrl #(
  parameter bit REPEAT_EN  = 1'b0,
  parameter int SECOND_CNT = 4,
  parameter int REPEAT_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  input  logic clear,
  output logic pulse
);

  localparam int            CW     = $clog2(SECOND_CNT + 1);
  localparam logic [CW-1:0] FIRST  = CW'(SECOND_CNT);
  localparam logic [CW-1:0] RELOAD = CW'(SECOND_CNT - SECOND_CNT / REPEAT_DIV);

  logic          key_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          press;
  logic          held;
  logic          fire;

  assign press   = key & ~key_d;
  assign held    = key & key_d;
  assign cnt_inc = cnt + CW'(1);
  // cnt holds clocks held since the press; reloading keeps later repeats one period apart.
  assign fire    = REPEAT_EN && held && !clear && (cnt_inc == FIRST);
  assign pulse   = press | fire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_d <= 1'b0;
      cnt   <= '0;
    end else begin
      key_d <= key;
      if (!REPEAT_EN || clear || !held)
        cnt <= '0;
      else if (fire)
        cnt <= RELOAD;
      else
        cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/alerm_set.sv
// Alarm-time setter: set key walks hour/min/sec edit fields, inc key bumps the
// selected BCD field (with hold-repeat), enable key toggles the arm flag.
module alerm_set
  import alerm_pkg::*;
#(
  parameter int second_cnt = 50000000,
  parameter int repeat_div = 4
) (
  input logic         clock,
  input logic         reset,
  alerm_set_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        field_q;
  logic [TIME_W-1:0] data_q;
  logic              flag;
  logic              flag_nxt;
  logic              enable_q;
  logic              set_pulse;
  logic              inc_pulse;
  logic              en_pulse;
  logic              inc_clear;
  logic              inc_act;

  alerm_key_ctrl #(.REPEAT_EN(1'b0), .SECOND_CNT(second_cnt), .REPEAT_DIV(repeat_div)) u_set (
    .clock (clock),
    .reset (reset),
    .key   (bus.set_key),
    .clear (1'b0),
    .pulse (set_pulse)
  );

  alerm_key_ctrl #(.REPEAT_EN(1'b1), .SECOND_CNT(second_cnt), .REPEAT_DIV(repeat_div)) u_inc (
    .clock (clock),
    .reset (reset),
    .key   (bus.inc_key),
    .clear (inc_clear),
    .pulse (inc_pulse)
  );

  alerm_key_ctrl #(.REPEAT_EN(1'b0), .SECOND_CNT(second_cnt), .REPEAT_DIV(repeat_div)) u_en (
    .clock (clock),
    .reset (reset),
    .key   (bus.enable_key),
    .clear (1'b0),
    .pulse (en_pulse)
  );

  // A set press takes priority over inc and restarts any repeat in progress.
  assign inc_clear = set_pulse | (state == IDLE);
  assign inc_act   = inc_pulse & ~set_pulse;

  always_comb begin
    state_nxt = state;
    if (set_pulse)
      state_nxt = next_state(state);
    flag_nxt = flag ^ en_pulse;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      field_q  <= FIELD_NONE;
      data_q   <= '0;
      flag     <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      field_q  <= field_of(state_nxt);
      flag     <= flag_nxt;
      enable_q <= flag_nxt && (state_nxt == IDLE);
      if (inc_act) begin
        case (state)
          SET_HOUR: data_q[HOUR_LSB +: FIELD_W] <= bcd_inc(data_q[HOUR_LSB +: FIELD_W], HOUR_MAX);
          SET_MIN:  data_q[MIN_LSB  +: FIELD_W] <= bcd_inc(data_q[MIN_LSB  +: FIELD_W], MINSEC_MAX);
          SET_SEC:  data_q[SEC_LSB  +: FIELD_W] <= bcd_inc(data_q[SEC_LSB  +: FIELD_W], MINSEC_MAX);
          default: ;
        endcase
      end
    end
  end

  assign bus.alerm_data   = data_q;
  assign bus.alerm_enable = enable_q;
  assign bus.edit_field   = field_q;

endmodule

// File: tb/tb_alerm_set.sv
// Directed bench for alerm_set with second_cnt=4, repeat_div=4; expectations
// are queued by the stimulus and compared by a negedge monitor.
module tb_alerm_set;

  typedef struct packed {
    logic [23:0] data;
    logic        en;
    logic [1:0]  field;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  alerm_set_if bus();

  alerm_set #(.second_cnt(4), .repeat_div(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t  sb[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;

  task automatic push_exp(input string n, input logic [23:0] d, input logic e, input logic [1:0] f);
    exp_t x;
    x.data  = d;
    x.en    = e;
    x.field = f;
    sb.push_back(x);
    sb_name.push_back(n);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // k: 0 = set, 1 = inc, 2 = enable
  task automatic press(input int k);
    case (k)
      0:       bus.set_key = 1'b1;
      1:       bus.inc_key = 1'b1;
      default: bus.enable_key = 1'b1;
    endcase
    tick();
    bus.set_key    = 1'b0;
    bus.inc_key    = 1'b0;
    bus.enable_key = 1'b0;
    tick();
  endtask

  // Monitor: compare every queued expectation against the outputs at the falling edge.
  initial begin
    exp_t  x;
    string n;
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        x = sb.pop_front();
        n = sb_name.pop_front();
        checks++;
        if (bus.alerm_data !== x.data || bus.alerm_enable !== x.en || bus.edit_field !== x.field) begin
          errors++;
          $display("FAIL %s: got data=%h en=%b field=%0d, expected data=%h en=%b field=%0d",
                   n, bus.alerm_data, bus.alerm_enable, bus.edit_field, x.data, x.en, x.field);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    bus.set_key    = 1'b0;
    bus.inc_key    = 1'b0;
    bus.enable_key = 1'b0;

    for (int i = 0; i < 4; i++) begin
      bus.set_key    = i[0];
      bus.inc_key    = ~i[0];
      bus.enable_key = i[1];
      tick();
      push_exp("rst_hold", 24'h000000, 1'b0, 2'd0);
    end
    bus.set_key    = 1'b0;
    bus.inc_key    = 1'b0;
    bus.enable_key = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    push_exp("rst_release", 24'h000000, 1'b0, 2'd0);

    press(0);
    push_exp("enter_hour", 24'h000000, 1'b0, 2'd1);
    repeat (3) press(1);
    push_exp("hour_03", 24'h030000, 1'b0, 2'd1);
    press(0);
    push_exp("enter_min", 24'h030000, 1'b0, 2'd2);
    press(0);
    press(0);
    push_exp("cycle_idle", 24'h030000, 1'b0, 2'd0);

    press(1);
    push_exp("inc_idle_ignored", 24'h030000, 1'b0, 2'd0);

    press(0);
    repeat (19) press(1);
    push_exp("hour_22", 24'h220000, 1'b0, 2'd1);
    press(1);
    push_exp("hour_23", 24'h230000, 1'b0, 2'd1);
    press(1);
    push_exp("hour_wrap", 24'h000000, 1'b0, 2'd1);
    press(1);
    push_exp("hour_01", 24'h010000, 1'b0, 2'd1);

    press(0);
    repeat (9) press(1);
    push_exp("min_09", 24'h010900, 1'b0, 2'd2);
    press(1);
    push_exp("min_carry", 24'h011000, 1'b0, 2'd2);
    repeat (49) press(1);
    push_exp("min_59", 24'h015900, 1'b0, 2'd2);
    press(1);
    push_exp("min_wrap", 24'h010000, 1'b0, 2'd2);

    press(0);
    push_exp("enter_sec", 24'h010000, 1'b0, 2'd3);

    // Hold inc: +1 at the press edge, +1 four clocks later, then +1 every clock.
    bus.inc_key = 1'b1;
    tick();
    push_exp("rep_press", 24'h010001, 1'b0, 2'd3);
    repeat (3) tick();
    push_exp("rep_wait", 24'h010001, 1'b0, 2'd3);
    tick();
    push_exp("rep_first", 24'h010002, 1'b0, 2'd3);
    repeat (16) tick();
    push_exp("rep_run", 24'h010018, 1'b0, 2'd3);
    bus.inc_key = 1'b0;
    repeat (4) tick();
    push_exp("rep_stop", 24'h010018, 1'b0, 2'd3);

    press(0);
    push_exp("sec_to_idle", 24'h010018, 1'b0, 2'd0);

    press(2);
    push_exp("en_on", 24'h010018, 1'b1, 2'd0);
    press(0);
    push_exp("en_masked_edit", 24'h010018, 1'b0, 2'd1);
    repeat (3) press(0);
    push_exp("en_restored", 24'h010018, 1'b1, 2'd0);

    press(0);
    bus.set_key = 1'b1;
    bus.inc_key = 1'b1;
    tick();
    push_exp("set_inc_same_edge", 24'h010018, 1'b0, 2'd2);
    bus.set_key = 1'b0;
    bus.inc_key = 1'b0;
    tick();

    bus.inc_key = 1'b1;
    repeat (6) tick();
    push_exp("rep_min", 24'h010318, 1'b0, 2'd2);
    // Pulse reset entirely between clock edges.
    @(negedge clock);
    #1;
    reset = 1'b0;
    push_exp("async_reset", 24'h000000, 1'b0, 2'd0);
    #2;
    reset = 1'b1;
    tick();
    bus.inc_key = 1'b0;
    tick();
    push_exp("post_reset", 24'h000000, 1'b0, 2'd0);

    press(0);
    press(2);
    push_exp("en_toggle_in_edit", 24'h000000, 1'b0, 2'd1);
    repeat (3) press(0);
    push_exp("en_kept", 24'h000000, 1'b1, 2'd0);

    repeat (3) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alerm_set.md
Name: alerm_set

Overview:
- Alarm-time setting unit: the writer side of the alarm compare path.
- Turns three debounced front-panel keys into the 24-bit BCD alarm time and the alarm enable flag that the alarm comparator consumes.
- Sits between the key debouncers and the alarm comparator, beside the timer.
- Also drives the field-select code used by the display for blinking.

Parameters:
- second_cnt, 50000000, clock cycles per second; the bench overrides it to 4.
- repeat_div, 4, auto-repeat period is second_cnt/repeat_div clocks; must be >=1 and divide second_cnt.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- set_key  input  1  debounced level, active-high; each press advances the edit field.
- inc_key  input  1  debounced level, active-high; increments the selected field, auto-repeats while held.
- enable_key  input  1  debounced level, active-high; each press toggles the alarm enable.
- alerm_data  output  24  alarm time as BCD {Ht,Ho,Mt,Mo,St,So}, 4 bits per digit.
- alerm_enable  output  1  alarm armed; forced 0 while editing.
- edit_field  output  2  0 = none, 1 = hour, 2 = minute, 3 = second.

Behaviour:
- Reset (reset=0, asynchronous), all registered:
  - alerm_data = 24'h000000, enable flag = 0, alerm_enable = 0.
  - state = IDLE, edit_field = 0, key history = 0, repeat counter = 0.
- Press detection:
  - Each key is registered once (key_d).
  - A press is key=1 && key_d=0 at a clock edge.
  - The resulting output update is registered on that same edge and is visible one cycle later.
- FSM states IDLE, SET_HOUR, SET_MIN, SET_SEC:
  - set press: IDLE -> SET_HOUR -> SET_MIN -> SET_SEC -> IDLE.
  - edit_field mirrors the state as 0, 1, 2, 3.
- Increment, only in the edit states:
  - inc press increments the selected field by 1 in BCD.
  - Ones digit 9 -> 0 with carry into the tens digit.
  - Hour wraps 23 -> 00; minute and second wrap 59 -> 00.
  - No carry between fields.
  - inc in IDLE is ignored.
- Auto-repeat:
  - While inc_key stays 1 in an edit state, a counter runs from the press.
  - After second_cnt clocks held: one extra increment.
  - Then one increment every second_cnt/repeat_div clocks until release.
  - Release, a state change, or reset clears the counter.
- Enable:
  - enable press toggles the internal enable flag in any state.
  - alerm_enable = flag && (state == IDLE), registered.
  - The flag value is kept across editing.
- Simultaneous events on the same edge:
  - set and inc presses together: set wins, inc is ignored, the repeat counter is cleared.
  - enable press is independent and always applied.
- Holding a key produces only one press; a new press requires a 0 sample first.
- Fields are never written outside the edit states, so alerm_data is stable in IDLE.
- Reset mid-edit or mid-repeat returns everything to reset values immediately.

Decomposition:
- Shared package alerm_pkg:
  - State encoding and edit_field codes (FIELD_NONE/HOUR/MIN/SEC).
  - BCD limits (HOUR_MAX = 8'h23, MINSEC_MAX = 8'h59).
  - Digit-slice constants for the 24-bit time word, shared with the timer and comparator.
- Sub-module alerm_key_ctrl, one instance per key:
  - Register and edge detect.
  - Optional auto-repeat counter enabled by a parameter.
  - Outputs a one-cycle action pulse.
- The top level holds the FSM, the BCD field incrementers and the enable logic.

Test Plan:
- Reset held low, keys toggling -> alerm_data=000000, alerm_enable=0, edit_field=0; release reset -> values hold.
- set press x1, inc press x3 -> edit_field=1, alerm_data=030000; set x3 more -> edit_field=0, data unchanged.
- SET_HOUR from 22 via two inc presses -> 23 then 00; SET_MIN from 09 -> 10; SET_MIN from 59 -> 00, hour untouched.
- second_cnt=4: in SET_SEC hold inc for 20 clocks from 00 -> 1 increment at press, 1 at clock 4, then 1 every clock -> seconds=18 at release (counted per rule); release -> stops.
- enable press in IDLE -> alerm_enable=1; set press -> alerm_enable=0; complete the edit cycle -> alerm_enable=1 again.
- set and inc rising on the same clock in SET_HOUR -> state SET_MIN, hour unchanged; assert reset mid-repeat -> all outputs 0 asynchronously.
